// File: rtl/divider_recompose_checker.sv
// Recomposes q*d + r with a serial shift-add multiplier and reports |n - recon|.
// Optional MAE totals (err_sum/sample_cnt/acc_clr) are enabled by DIVCHK_MAE_ACC_EN.
module divider_recompose_checker #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] recon,
  output logic [2*WIDTH-1:0] err,
`ifdef DIVCHK_MAE_ACC_EN
  input  logic               acc_clr,
  output logic [31:0]        err_sum,
  output logic [15:0]        sample_cnt,
`endif
  output logic               mismatch
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ERR, DONE} state_t;
  state_t state, state_nxt;

  logic [W2-1:0]    n_q, acc, mcand;
  logic [WIDTH-1:0] q_sh;
  logic [CW-1:0]    cnt;
  logic             hs;

  assign hs = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL:  if (cnt == CW'(WIDTH - 1)) state_nxt = ERR;
      ERR:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplicand shifts left and quotient shifts right, so bit cnt of q
  // always meets d << cnt without a variable shifter.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n_q      <= '0;
      acc      <= '0;
      mcand    <= '0;
      q_sh     <= '0;
      cnt      <= '0;
      recon    <= '0;
      err      <= '0;
      mismatch <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          n_q   <= n;
          mcand <= {{WIDTH{1'b0}}, d};
          q_sh  <= q;
          acc   <= {{WIDTH{1'b0}}, r};
          cnt   <= '0;
        end
        MUL: begin
          if (q_sh[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          q_sh  <= q_sh >> 1;
          cnt   <= cnt + CW'(1);
        end
        ERR: begin
          recon    <= acc;
          err      <= (n_q >= acc) ? (n_q - acc) : (acc - n_q);
          mismatch <= (n_q != acc);
        end
        default: ;
      endcase
    end

`ifdef DIVCHK_MAE_ACC_EN
  logic [32:0] sum_nxt;
  assign sum_nxt = {1'b0, err_sum} + 33'(err);

  // Clear takes priority over a coincident handshake.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_sum    <= '0;
      sample_cnt <= '0;
    end else if (acc_clr) begin
      err_sum    <= '0;
      sample_cnt <= '0;
    end else if (hs) begin
      err_sum    <= sum_nxt[32] ? 32'hFFFF_FFFF : sum_nxt[31:0];
      sample_cnt <= (&sample_cnt) ? sample_cnt : sample_cnt + 16'd1;
    end
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_divider_recompose_checker.sv
// Directed bench for divider_recompose_checker; MAE checks build with DIVCHK_MAE_ACC_EN.
module tb_divider_recompose_checker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] n;
  logic [7:0]  d, q, r;
  logic        out_valid, out_ready;
  logic [15:0] recon, err;
  logic        mismatch;
`ifdef DIVCHK_MAE_ACC_EN
  logic        acc_clr;
  logic [31:0] err_sum;
  logic [15:0] sample_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divider_recompose_checker #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .recon     (recon),
    .err       (err),
`ifdef DIVCHK_MAE_ACC_EN
    .acc_clr   (acc_clr),
    .err_sum   (err_sum),
    .sample_cnt(sample_cnt),
`endif
    .mismatch  (mismatch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, measure latency, hold off the consumer for `hold`
  // cycles while pushing a junk sample, then complete the handshake.
  task automatic run(input string tag, input logic [15:0] tn, input logic [7:0] td,
                     input logic [7:0] tq, input logic [7:0] tr,
                     input logic [15:0] e_recon, input logic [15:0] e_err,
                     input logic e_mis, input int hold);
    int cyc;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    n = tn; d = td; q = tq; r = tr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; n = '1; d = '1; q = '1; r = '1;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"},  32'(cyc),      32'd9);
    chk({tag, ".recon"},    32'(recon),    32'(e_recon));
    chk({tag, ".err"},      32'(err),      32'(e_err));
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(e_mis));
    chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; n = 16'd7; d = 8'd1; q = 8'd1; r = 8'd1;
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_recon"}, 32'(recon),     32'(e_recon));
      chk({tag, ".hold_err"},   32'(err),       32'(e_err));
      chk({tag, ".hold_ready"}, 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk({tag, ".ov_fall"}, 32'(out_valid), 32'd0);
    chk({tag, ".ir_rise"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n = '0; d = '0; q = '0; r = '0;
`ifdef DIVCHK_MAE_ACC_EN
    acc_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.recon",     32'(recon),     32'd0);
    chk("rst.err",       32'(err),       32'd0);
    chk("rst.mismatch",  32'(mismatch),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
`ifdef DIVCHK_MAE_ACC_EN
    chk("rst.err_sum",    err_sum,            32'd0);
    chk("rst.sample_cnt", 32'(sample_cnt),    32'd0);
`endif

    run("approx",    16'd1000, 8'd7,  8'd140, 8'd3,   16'd983,   16'd17,  1'b1, 0);
    run("exact",     16'd1000, 8'd7,  8'd142, 8'd6,   16'd1000,  16'd0,   1'b0, 0);
    run("overshoot", 16'd50,   8'd10, 8'd6,   8'd0,   16'd60,    16'd10,  1'b1, 0);
`ifdef DIVCHK_MAE_ACC_EN
    chk("mae.err_sum",    err_sum,         32'd27);
    chk("mae.sample_cnt", 32'(sample_cnt), 32'd3);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk("mae.clr_sum", err_sum,         32'd0);
    chk("mae.clr_cnt", 32'(sample_cnt), 32'd0);
`endif
    run("boundary",  16'd65535, 8'd255, 8'd255, 8'd255, 16'd65280, 16'd255, 1'b1, 0);
    run("dzero",     16'd300,   8'd0,   8'd99,  8'd20,  16'd20,    16'd280, 1'b1, 0);
    run("backpress", 16'd100,   8'd9,   8'd10,  8'd5,   16'd95,    16'd5,   1'b1, 5);
`ifdef DIVCHK_MAE_ACC_EN
    chk("mae.after_sum", err_sum,         32'd540);
    chk("mae.after_cnt", 32'(sample_cnt), 32'd3);
`endif

    // Abandon a transaction partway through the multiply.
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    n = 16'd1000; d = 8'd7; q = 8'd142; r = 8'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.recon",     32'(recon),     32'd0);
    chk("midrst.err",       32'(err),       32'd0);
    chk("midrst.mismatch",  32'(mismatch),  32'd0);
`ifdef DIVCHK_MAE_ACC_EN
    chk("midrst.err_sum",   err_sum,        32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst.no_output", 32'(out_valid), 32'd0);
    run("fresh", 16'd12, 8'd3, 8'd4, 8'd0, 16'd12, 16'd0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/divider_recompose_checker.md
Name: divider_recompose_checker

Overview:
- Sequential inverse of the 16/8 array divider: takes a dividend/divisor pair and the divider's quotient/remainder, reconstructs recon = q*d + r with a shift-add multiplier, and reports the absolute error |n - recon|.
- Sits beside exact or approximate divider instances in the error-characterisation harness, supplying per-sample error distance for MAE evaluation.
- One result per transaction; valid/ready handshake on input and output.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; dividend, reconstruction and error are 2*WIDTH bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample (high only in IDLE).
- n  input  2*WIDTH  dividend fed to the divider.
- d  input  WIDTH  divisor.
- q  input  WIDTH  quotient under test.
- r  input  WIDTH  remainder under test.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- recon  output  2*WIDTH  q*d + r.
- err  output  2*WIDTH  |n - recon|.
- mismatch  output  1  err != 0.

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1 once released; out_valid=0; recon=0; err=0; mismatch=0; internal registers cleared. Reset mid-operation abandons the transaction with no output.
- States: IDLE, MUL, ERR, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge E0, latch n, d and q; initialise acc=r (zero-extended to 2*WIDTH), set bit counter=0, and go to MUL.
- MUL: one quotient bit per cycle, LSB first. If q_latched[cnt]=1, add (d << cnt) to acc. Increment cnt. After WIDTH cycles (edges E1..E_WIDTH), go to ERR. in_ready=0.
- ERR: one cycle (edge E_WIDTH+1). Register recon=acc and err = (n>=acc) ? n-acc : acc-n. Register mismatch=(err!=0) and set out_valid=1. Go to DONE.
- Latency: out_valid is high after edge WIDTH+1 following the accept edge, i.e. 9 cycles for the default.
- DONE: out_valid=1. recon, err and mismatch are stable. On out_valid&out_ready, clear out_valid and return to IDLE; in_ready rises in the next cycle. There is no accept in the same cycle as the output handshake.
- Width: acc is 2*WIDTH bits. The maximum value (2^WIDTH-1)^2 + (2^WIDTH-1) < 2^(2*WIDTH), so no overflow and no saturation logic.
- d=0: recon=r, err=|n-r|. q=0: no additions, recon=r.
- in_valid while busy is ignored; inputs are not required to stay stable after accept.
- Output registers keep their last values in IDLE/MUL; only out_valid qualifies them.

Optional Feature:
- Macro DIVCHK_MAE_ACC_EN.
- Defined: adds input acc_clr (1 bit) and outputs err_sum (32 bits) and sample_cnt (16 bits), all reset to 0.
  - On each output handshake, err_sum += err (saturating at 2^32-1) and sample_cnt += 1 (saturating at 2^16-1).
  - acc_clr high zeroes both on the next edge. If acc_clr coincides with a handshake, the clear wins and the sample is dropped from the totals.
- Undefined: these ports and registers are absent; the core behaviour is identical.

Test Plan:
- Exact pair n=1000, d=7, q=142, r=6 -> out_valid 9 cycles after accept, recon=1000, err=0, mismatch=0.
- Approximate output n=1000, d=7, q=140, r=3 -> recon=983, err=17, mismatch=1.
- Overshoot n=50, d=10, q=6, r=0 -> recon=60, err=10. Boundary n=65535, d=255, q=255, r=255 -> recon=65280, err=255.
- Backpressure: out_ready=0 for 5 cycles -> out_valid held, outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> out_valid falls and in_ready=1 on the next cycle.
- Reset mid-MUL (rst_n low at cycle 4) -> out_valid=0 and recon/err=0 immediately. After release, a fresh sample n=12, d=3, q=4, r=0 gives recon=12, err=0.
- With DIVCHK_MAE_ACC_EN: three samples with err 17, 0, 10 -> err_sum=27, sample_cnt=3. Then acc_clr pulse -> both 0.
